// File: rtl/sb_write_ctrl.sv
// rtl/sb_write_ctrl.sv - shared-buffer packet writer with free-address FIFO and linked-list RAM writes
// Each written word carries the address of its successor so the reader can walk the packet.
module sb_write_ctrl #(
  parameter int SHARED_BUFFER_ADDR_BITWIDTH = 13,
  parameter int SHARED_BUFFER_DATA_BITWIDTH = 86
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [71:0]                            in_data,
  input  logic                                   in_eop,
  output logic                                   wr_en,
  output logic [SHARED_BUFFER_ADDR_BITWIDTH-1:0] w_addr,
  output logic [SHARED_BUFFER_DATA_BITWIDTH-1:0] w_data,
  input  logic                                   rel_valid,
  input  logic [SHARED_BUFFER_ADDR_BITWIDTH-1:0] rel_addr,
  output logic                                   desc_valid,
  output logic [SHARED_BUFFER_ADDR_BITWIDTH-1:0] desc_head,
  output logic [SHARED_BUFFER_ADDR_BITWIDTH:0]   desc_len,
  output logic [SHARED_BUFFER_ADDR_BITWIDTH:0]   free_cnt,
  output logic                                   init_done,
  output logic                                   err
);

  localparam int A     = SHARED_BUFFER_ADDR_BITWIDTH;
  localparam int DEPTH = 1 << A;

  typedef enum logic [1:0] {S_INIT, S_ALLOC, S_RECV} state_t;

  state_t       state;
  logic [A-1:0] fifo_mem [DEPTH];
  logic [A-1:0] rd_ptr;
  logic [A-1:0] wr_ptr;
  logic [A:0]   count;
  logic [A-1:0] init_cnt;
  logic [A-1:0] cur_addr;
  logic [A-1:0] head_addr;
  logic [A:0]   len_cnt;

  logic         fifo_empty;
  logic         fifo_full;
  logic         accept;
  logic         pop;
  logic         push;
  logic         rel_err;
  logic [A-1:0] push_data;
  logic [A-1:0] fifo_head;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == {1'b1, {A{1'b0}}});
  assign fifo_head  = fifo_mem[rd_ptr];

  // The eop word never needs a successor, so it may be taken even when the pool is dry.
  assign in_ready = (state == S_RECV) && (in_eop || !fifo_empty);
  assign accept   = in_valid && in_ready;

  assign pop = ((state == S_ALLOC) && !fifo_empty) || (accept && !in_eop);

  always_comb begin
    push      = 1'b0;
    push_data = rel_addr;
    rel_err   = 1'b0;
    if (state == S_INIT) begin
      push      = 1'b1;
      push_data = init_cnt;
      rel_err   = rel_valid;
    end else if (rel_valid) begin
      push    = !fifo_full;
      rel_err = fifo_full;
    end
  end

  assign wr_en      = accept;
  assign w_addr     = cur_addr;
  assign w_data     = {in_eop, (in_eop ? {A{1'b0}} : fifo_head), in_data};
  assign desc_valid = accept && in_eop;
  assign desc_head  = head_addr;
  assign desc_len   = len_cnt + 1'b1;
  assign free_cnt   = count;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      init_cnt  <= '0;
      cur_addr  <= '0;
      head_addr <= '0;
      len_cnt   <= '0;
      init_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (rel_err) begin
        err <= 1'b1;
      end
      case (state)
        S_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == {A{1'b1}}) begin
            state     <= S_ALLOC;
            init_done <= 1'b1;
          end
        end
        S_ALLOC: begin
          if (!fifo_empty) begin
            cur_addr  <= fifo_head;
            head_addr <= fifo_head;
            len_cnt   <= '0;
            state     <= S_RECV;
          end
        end
        S_RECV: begin
          if (accept) begin
            if (in_eop) begin
              state <= S_ALLOC;
            end else begin
              cur_addr <= fifo_head;
              len_cnt  <= len_cnt + 1'b1;
            end
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sb_write_ctrl.sv
// tb/tb_sb_write_ctrl.sv - scoreboard bench for sb_write_ctrl
module tb_sb_write_ctrl;

  localparam int A  = 13;
  localparam int DW = 86;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [71:0]   in_data = '0;
  logic          in_eop = 1'b0;
  logic          wr_en;
  logic [A-1:0]  w_addr;
  logic [DW-1:0] w_data;
  logic          rel_valid = 1'b0;
  logic [A-1:0]  rel_addr = '0;
  logic          desc_valid;
  logic [A-1:0]  desc_head;
  logic [A:0]    desc_len;
  logic [A:0]    free_cnt;
  logic          init_done;
  logic          err;

  int checks = 0;
  int failures = 0;

  logic [A+DW-1:0] exp_wr[$];
  logic [2*A:0]    exp_desc[$];

  sb_write_ctrl #(.SHARED_BUFFER_ADDR_BITWIDTH(A), .SHARED_BUFFER_DATA_BITWIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_eop(in_eop), .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data), .rel_valid(rel_valid),
    .rel_addr(rel_addr), .desc_valid(desc_valid), .desc_head(desc_head), .desc_len(desc_len),
    .free_cnt(free_cnt), .init_done(init_done), .err(err)
  );

  always #5 clk = ~clk;

  // Output side of the scoreboard: every RAM write and descriptor must match the next expectation.
  always @(negedge clk) begin
    logic [A+DW-1:0] ew;
    logic [2*A:0]    ed;
    if (wr_en === 1'b1) begin
      checks++;
      if (exp_wr.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected got addr=%0d data=%h required none", w_addr, w_data);
      end else begin
        ew = exp_wr.pop_front();
        if ({w_addr, w_data} !== ew) begin
          failures++;
          $display("FAIL wr_word got addr=%0d data=%h required addr=%0d data=%h",
                   w_addr, w_data, ew[A+DW-1:DW], ew[DW-1:0]);
        end
      end
    end
    if (desc_valid === 1'b1) begin
      checks++;
      if (exp_desc.size() == 0) begin
        failures++;
        $display("FAIL desc_unexpected got head=%0d len=%0d required none", desc_head, desc_len);
      end else begin
        ed = exp_desc.pop_front();
        if ({desc_head, desc_len} !== ed) begin
          failures++;
          $display("FAIL desc got head=%0d len=%0d required head=%0d len=%0d",
                   desc_head, desc_len, ed[2*A:A+1], ed[A:0]);
        end
      end
    end
  end

  function automatic logic [71:0] rand72();
    return {$urandom_range(255, 0), $urandom(), $urandom()};
  endfunction

  task automatic send_word(input logic [71:0] d, input logic eop, input int addr, input int nxt,
                           output int waited);
    logic [A-1:0] a;
    logic [A-1:0] n;
    bit done;
    a = A'(addr);
    n = eop ? '0 : A'(nxt);
    exp_wr.push_back({a, eop, n, d});
    in_valid = 1'b1;
    in_data  = d;
    in_eop   = eop;
    waited   = 0;
    done     = 0;
    while (!done) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        done = 1;
      end else begin
        waited++;
        if (waited > 100) begin
          checks++;
          failures++;
          $display("FAIL send_timeout got in_ready=%b required 1 at addr=%0d", in_ready, addr);
          done = 1;
        end
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (init_done !== 1'b1 && n < 9000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, wr_en, desc_valid, init_done, err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got %b required 00000", {in_ready, wr_en, desc_valid, init_done, err});
    end
    checks++;
    if (free_cnt !== 14'd0) begin
      failures++;
      $display("FAIL reset_free_cnt got %0d required 0", free_cnt);
    end
  endtask

  task automatic test_init();
    int n;
    release_reset();
    wait_init(n);
    checks++;
    if (n !== 8192) begin
      failures++;
      $display("FAIL init_cycles got %0d required 8192", n);
    end
    checks++;
    if (free_cnt !== 14'd8192 || in_ready !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL init_done_state got free=%0d rdy=%b err=%b required 8192 0 0", free_cnt, in_ready, err);
    end
    @(posedge clk);
    #1;
    checks++;
    if (free_cnt !== 14'd8191 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL first_alloc got free=%0d rdy=%b required 8191 1", free_cnt, in_ready);
    end
  endtask

  task automatic test_three_word();
    int w;
    exp_desc.push_back({13'd0, 14'd3});
    send_word(rand72(), 1'b0, 0, 1, w);
    send_word(rand72(), 1'b0, 1, 2, w);
    send_word(rand72(), 1'b1, 2, 0, w);
    checks++;
    if (free_cnt !== 14'd8189) begin
      failures++;
      $display("FAIL three_word_free got %0d required 8189", free_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    in_valid = 1'b1;
    in_eop   = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || wr_en !== 1'b0) begin
      failures++;
      $display("FAIL bubble got rdy=%b wr_en=%b required 0 0", in_ready, wr_en);
    end
    @(posedge clk);
    #1;
    exp_desc.push_back({13'd3, 14'd1});
    send_word(rand72(), 1'b1, 3, 0, w);
    checks++;
    if (w !== 0) begin
      failures++;
      $display("FAIL single_word_wait got %0d required 0", w);
    end
  endtask

  task automatic test_mid_reset();
    int w;
    int n;
    send_word(rand72(), 1'b0, 4, 5, w);
    send_word(rand72(), 1'b0, 5, 6, w);
    in_valid = 1'b1;
    in_eop   = 1'b0;
    in_data  = rand72();
    rst_n    = 1'b0;
    #1;
    checks++;
    if ({wr_en, desc_valid, in_ready} !== 3'b0 || free_cnt !== 14'd0) begin
      failures++;
      $display("FAIL mid_reset got wr=%b desc=%b rdy=%b free=%0d required 0 0 0 0",
               wr_en, desc_valid, in_ready, free_cnt);
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
    wait_init(n);
    checks++;
    if (n !== 8192 || free_cnt !== 14'd8192) begin
      failures++;
      $display("FAIL reinit got cycles=%0d free=%0d required 8192 8192", n, free_cnt);
    end
  endtask

  task automatic test_exhaust();
    int w;
    exp_desc.push_back({13'd0, 14'd8192});
    for (int i = 0; i < 8191; i++) begin
      send_word(rand72(), 1'b0, i, i + 1, w);
    end
    checks++;
    if (free_cnt !== 14'd0) begin
      failures++;
      $display("FAIL exhaust_free got %0d required 0", free_cnt);
    end
    in_valid = 1'b1;
    in_eop   = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || wr_en !== 1'b0) begin
      failures++;
      $display("FAIL exhaust_stall got rdy=%b wr_en=%b required 0 0", in_ready, wr_en);
    end
    @(posedge clk);
    #1;
    send_word(rand72(), 1'b1, 8191, 0, w);
    checks++;
    if (w !== 0) begin
      failures++;
      $display("FAIL exhaust_eop_wait got %0d required 0", w);
    end
    rel_valid = 1'b1;
    rel_addr  = 13'd5;
    @(posedge clk);
    #1;
    rel_valid = 1'b0;
    checks++;
    if (free_cnt !== 14'd1) begin
      failures++;
      $display("FAIL release_free got %0d required 1", free_cnt);
    end
    exp_desc.push_back({13'd5, 14'd1});
    send_word(rand72(), 1'b1, 5, 0, w);
  endtask

  task automatic test_release_full();
    int n;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
    wait_init(n);
    checks++;
    if (err !== 1'b0 || free_cnt !== 14'd8192) begin
      failures++;
      $display("FAIL full_pre got err=%b free=%0d required 0 8192", err, free_cnt);
    end
    rel_valid = 1'b1;
    rel_addr  = 13'd7;
    @(posedge clk);
    #1;
    rel_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || free_cnt !== 14'd8191) begin
      failures++;
      $display("FAIL full_release got err=%b free=%0d required 1 8191", err, free_cnt);
    end
  endtask

  task automatic test_release_init();
    int n;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_reset got %b required 0", err);
    end
    release_reset();
    repeat (50) @(posedge clk);
    #1;
    rel_valid = 1'b1;
    rel_addr  = 13'd3;
    @(posedge clk);
    #1;
    rel_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || free_cnt !== 14'd51) begin
      failures++;
      $display("FAIL init_release got err=%b free=%0d required 1 51", err, free_cnt);
    end
    wait_init(n);
    checks++;
    if (n + 51 !== 8192 || free_cnt !== 14'd8192) begin
      failures++;
      $display("FAIL init_release_done got cycles=%0d free=%0d required 8192 8192", n + 51, free_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_three_word();
    test_back_to_back();
    test_mid_reset();
    test_exhaust();
    test_release_full();
    test_release_init();
    repeat (2) @(posedge clk);
    checks++;
    if (exp_wr.size() != 0 || exp_desc.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left got wr=%0d desc=%0d required 0 0", exp_wr.size(), exp_desc.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
